sram_phase_sequencer: RTL

- Top-level controller for the image decoder that owns the single external SRAM port.
- Sequences the phases UART load -> Milestone 2 (IDCT) -> Milestone 1 (upsample/colour-convert) -> VGA display.
- Grants the SRAM port to exactly one master per phase. Issues single-cycle start pulses and waits for each done.
- Inserts guard cycles with writes suppressed between owners. A per-phase watchdog traps hung milestones.

---
 rtl/sram_phase_sequencer_pkg.sv | 43 ++++
 rtl/sram_port_mux.sv | 25 ++
 rtl/sram_phase_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sram_phase_sequencer_pkg.sv
// Shared types for the SRAM phase sequencer: FSM states, owner grant codes and
// the packed SRAM request bundle carried from each master to the port mux.
package sram_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        S_TOP_IDLE,
        S_TOP_HANDOVER,
        S_TOP_UART_RX,
        S_TOP_M2_RUN,
        S_TOP_M1_RUN,
        S_TOP_DISPLAY,
        S_TOP_ERROR
    } top_state_type;

    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_UART = 3'd1;
    localparam logic [2:0] OWN_M2   = 3'd2;
    localparam logic [2:0] OWN_M1   = 3'd3;
    localparam logic [2:0] OWN_VGA  = 3'd4;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic                   we_n;
    } sram_req_t;

    // Parked port value: nobody writes while the port is unowned.
    localparam sram_req_t SRAM_IDLE_REQ = '{addr: '0, wdata: '0, we_n: 1'b1};

    function automatic top_state_type owner_to_state(input logic [2:0] own);
        case (own)
            OWN_UART: owner_to_state = S_TOP_UART_RX;
            OWN_M2:   owner_to_state = S_TOP_M2_RUN;
            OWN_M1:   owner_to_state = S_TOP_M1_RUN;
            OWN_VGA:  owner_to_state = S_TOP_DISPLAY;
            default:  owner_to_state = S_TOP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Combinational SRAM port mux: passes the owning master's request straight through.
// Zero latency; no backpressure, an unowned port parks at address 0 with writes off.
module sram_port_mux
    import sram_phase_sequencer_pkg::*;
(
    input  logic [2:0] owner,
    input  sram_req_t  uart_req,
    input  sram_req_t  m2_req,
    input  sram_req_t  m1_req,
    input  sram_req_t  vga_req,
    output sram_req_t  sram_req
);

    always_comb begin
        sram_req = SRAM_IDLE_REQ;
        case (owner)
            OWN_UART: sram_req = uart_req;
            OWN_M2:   sram_req = m2_req;
            OWN_M1:   sram_req = m1_req;
            OWN_VGA:  sram_req = vga_req;
            default:  sram_req = SRAM_IDLE_REQ;
        endcase
    end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Phase sequencer owning the SRAM port: UART -> M2 -> M1 -> VGA with guarded handovers.
// Done-to-next-start latency GUARD_CYCLES+1; masters are never stalled, only granted.
module sram_phase_sequencer
    import sram_phase_sequencer_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 2,
    parameter logic [31:0] WATCHDOG_LIMIT = 32'd4000000
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        top_start,
    input  logic        skip_m2,
    input  logic        UART_done,
    input  logic        M2_done,
    input  logic        M1_done,
    output logic        UART_start,
    output logic        M2_start,
    output logic        M1_start,
    output logic        VGA_enable,
    input  logic [17:0] UART_SRAM_address,
    input  logic [15:0] UART_SRAM_write_data,
    input  logic        UART_SRAM_we_n,
    input  logic [17:0] M2_SRAM_address,
    input  logic [15:0] M2_SRAM_write_data,
    input  logic        M2_SRAM_we_n,
    input  logic [17:0] M1_SRAM_address,
    input  logic [15:0] M1_SRAM_write_data,
    input  logic        M1_SRAM_we_n,
    input  logic [17:0] VGA_SRAM_address,
    input  logic [15:0] VGA_SRAM_write_data,
    input  logic        VGA_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  owner,
    output logic        busy,
    output logic        wdog_error,
    output logic [2:0]  err_phase
);

    localparam logic [3:0]  GUARD_LAST = 4'(GUARD_CYCLES - 1);
    localparam logic [31:0] WDOG_LAST  = WATCHDOG_LIMIT - 32'd1;
    localparam logic        WDOG_EN    = (WATCHDOG_LIMIT != 32'd0);

    top_state_type state_q, state_d;
    logic [2:0]    next_q, next_d;
    logic [2:0]    owner_q, owner_d;
    logic [3:0]    guard_q, guard_d;
    logic [31:0]   wdog_cnt_q, wdog_cnt_d;
    logic          uart_start_q, uart_start_d;
    logic          m2_start_q, m2_start_d;
    logic          m1_start_q, m1_start_d;
    logic          vga_en_q, vga_en_d;
    logic          busy_q, busy_d;
    logic          wdog_error_q, wdog_error_d;
    logic [2:0]    err_phase_q, err_phase_d;

    logic          run_done;
    logic          wdog_hit;

    // The start flop doubles as the first-cycle marker, masking done in that cycle.
    assign run_done = ((state_q == S_TOP_M2_RUN) && M2_done && !m2_start_q) ||
                      ((state_q == S_TOP_M1_RUN) && M1_done && !m1_start_q);
    assign wdog_hit = WDOG_EN && (wdog_cnt_q == WDOG_LAST);

    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        owner_d      = owner_q;
        guard_d      = guard_q;
        wdog_cnt_d   = wdog_cnt_q;
        uart_start_d = 1'b0;
        m2_start_d   = 1'b0;
        m1_start_d   = 1'b0;
        wdog_error_d = wdog_error_q;
        err_phase_d  = err_phase_q;

        case (state_q)
            S_TOP_IDLE, S_TOP_DISPLAY, S_TOP_ERROR: begin
                if (top_start) begin
                    state_d      = S_TOP_HANDOVER;
                    next_d       = OWN_UART;
                    owner_d      = OWN_NONE;
                    guard_d      = '0;
                    wdog_error_d = 1'b0;
                end
            end
            S_TOP_HANDOVER: begin
                if (guard_q == GUARD_LAST) begin
                    state_d      = owner_to_state(next_q);
                    owner_d      = next_q;
                    guard_d      = '0;
                    wdog_cnt_d   = '0;
                    uart_start_d = (next_q == OWN_UART);
                    m2_start_d   = (next_q == OWN_M2);
                    m1_start_d   = (next_q == OWN_M1);
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            S_TOP_UART_RX: begin
                if (UART_done && !uart_start_q) begin
                    state_d = S_TOP_HANDOVER;
                    owner_d = OWN_NONE;
                    guard_d = '0;
                    next_d  = skip_m2 ? OWN_M1 : OWN_M2;
                end
            end
            S_TOP_M2_RUN, S_TOP_M1_RUN: begin
                // Done is checked before expiry so a last-cycle completion still counts.
                if (run_done) begin
                    state_d = S_TOP_HANDOVER;
                    owner_d = OWN_NONE;
                    guard_d = '0;
                    next_d  = (state_q == S_TOP_M2_RUN) ? OWN_M1 : OWN_VGA;
                end else if (wdog_hit) begin
                    state_d      = S_TOP_ERROR;
                    owner_d      = OWN_NONE;
                    wdog_error_d = 1'b1;
                    err_phase_d  = owner_q;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_TOP_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        vga_en_d = (state_d == S_TOP_DISPLAY);
        busy_d   = !((state_d == S_TOP_IDLE) || (state_d == S_TOP_DISPLAY) ||
                     (state_d == S_TOP_ERROR));
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_q      <= S_TOP_IDLE;
            next_q       <= OWN_NONE;
            owner_q      <= OWN_NONE;
            guard_q      <= '0;
            wdog_cnt_q   <= '0;
            uart_start_q <= 1'b0;
            m2_start_q   <= 1'b0;
            m1_start_q   <= 1'b0;
            vga_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            wdog_error_q <= 1'b0;
            err_phase_q  <= OWN_NONE;
        end else begin
            state_q      <= state_d;
            next_q       <= next_d;
            owner_q      <= owner_d;
            guard_q      <= guard_d;
            wdog_cnt_q   <= wdog_cnt_d;
            uart_start_q <= uart_start_d;
            m2_start_q   <= m2_start_d;
            m1_start_q   <= m1_start_d;
            vga_en_q     <= vga_en_d;
            busy_q       <= busy_d;
            wdog_error_q <= wdog_error_d;
            err_phase_q  <= err_phase_d;
        end
    end

    assign UART_start = uart_start_q;
    assign M2_start   = m2_start_q;
    assign M1_start   = m1_start_q;
    assign VGA_enable = vga_en_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign wdog_error = wdog_error_q;
    assign err_phase  = err_phase_q;

    sram_req_t uart_req, m2_req, m1_req, vga_req, sram_req;

    assign uart_req = '{addr: UART_SRAM_address, wdata: UART_SRAM_write_data, we_n: UART_SRAM_we_n};
    assign m2_req   = '{addr: M2_SRAM_address,   wdata: M2_SRAM_write_data,   we_n: M2_SRAM_we_n};
    assign m1_req   = '{addr: M1_SRAM_address,   wdata: M1_SRAM_write_data,   we_n: M1_SRAM_we_n};
    assign vga_req  = '{addr: VGA_SRAM_address,  wdata: VGA_SRAM_write_data,  we_n: VGA_SRAM_we_n};

    sram_port_mux u_port_mux (
        .owner    (owner_q),
        .uart_req (uart_req),
        .m2_req   (m2_req),
        .m1_req   (m1_req),
        .vga_req  (vga_req),
        .sram_req (sram_req)
    );

    assign SRAM_address    = sram_req.addr;
    assign SRAM_write_data = sram_req.wdata;
    assign SRAM_we_n       = sram_req.we_n;

endmodule
